// File: rtl/vending_pkg.sv
// Shared request modes, error codes and FSM states for the vending core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vending_pkg;

    localparam logic [1:0] MODE_QUERY    = 2'd0;
    localparam logic [1:0] MODE_BUY      = 2'd1;
    localparam logic [1:0] MODE_RESTOCK  = 2'd2;
    localparam logic [1:0] MODE_SETPRICE = 2'd3;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BADTYPE   = 3'd1;
    localparam logic [2:0] ERR_ZEROQTY   = 3'd2;
    localparam logic [2:0] ERR_NOSTOCK   = 3'd3;
    localparam logic [2:0] ERR_NOMONEY   = 3'd4;
    localparam logic [2:0] ERR_OVERSTOCK = 3'd5;
    localparam logic [2:0] ERR_BANKFULL  = 3'd6;
    localparam logic [2:0] ERR_ZEROPRICE = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_COMMIT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/vending_slot_bank.sv
// Per-slot stock and price registers with one read port and one commit port.
// Latency: combinational read, write visible the cycle after wr_en.
// Backpressure: none; out-of-range read index returns zeros.
module vending_slot_bank
    import vending_pkg::*;
#(
    parameter int N_TYPES       = 8,
    parameter int TYPE_W        = 3,
    parameter int QTY_W         = 4,
    parameter int MONEY_W       = 7,
    parameter int PRICE_DEFAULT = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [TYPE_W-1:0]  rd_type,
    output logic [QTY_W-1:0]   rd_stock,
    output logic [MONEY_W-1:0] rd_price,
    input  logic               wr_en,
    input  logic [TYPE_W-1:0]  wr_type,
    input  logic [QTY_W-1:0]   wr_stock,
    input  logic [MONEY_W-1:0] wr_price
);

    logic [QTY_W-1:0]   stock_q [N_TYPES];
    logic [MONEY_W-1:0] price_q [N_TYPES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TYPES; i++) begin
                stock_q[i] <= '0;
                price_q[i] <= MONEY_W'(PRICE_DEFAULT);
            end
        end else if (wr_en) begin
            for (int i = 0; i < N_TYPES; i++) begin
                if (TYPE_W'(i) == wr_type) begin
                    stock_q[i] <= wr_stock;
                    price_q[i] <= wr_price;
                end
            end
        end
    end

    always_comb begin
        rd_stock = '0;
        rd_price = '0;
        for (int i = 0; i < N_TYPES; i++) begin
            if (TYPE_W'(i) == rd_type) begin
                rd_stock = stock_q[i];
                rd_price = price_q[i];
            end
        end
    end

endmodule

// File: rtl/vending_core_param.sv
// Multi-slot vending engine: query/buy/restock/set_price against slot bank and cash register.
// Latency: resp_valid 3 cycles after the accepting edge; one request per 4 cycles.
// Backpressure: req_ready low outside IDLE; requests offered while busy are ignored.
module vending_core_param
    import vending_pkg::*;
#(
    parameter int N_TYPES       = 8,
    parameter int TYPE_W        = 3,
    parameter int QTY_W         = 4,
    parameter int MAX_STOCK     = 15,
    parameter int MONEY_W       = 7,
    parameter int BANK_W        = 12,
    parameter int PRICE_DEFAULT = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         mode,
    input  logic [TYPE_W-1:0]  supply_type,
    input  logic [QTY_W-1:0]   customer_amount,
    input  logic [MONEY_W-1:0] customer_money,
    output logic               resp_valid,
    output logic [2:0]         error,
    output logic [MONEY_W-1:0] change,
    output logic [QTY_W-1:0]   stock_out,
    output logic [BANK_W-1:0]  machineMoney
);

    localparam int COST_W = MONEY_W + QTY_W;
    localparam int SUM_W  = ((BANK_W > COST_W) ? BANK_W : COST_W) + 1;
    localparam logic [SUM_W-1:0] BANK_MAX = {{(SUM_W-BANK_W){1'b0}}, {BANK_W{1'b1}}};

    state_t state_q, state_d;

    logic [1:0]         mode_q;
    logic [TYPE_W-1:0]  type_q;
    logic [QTY_W-1:0]   amt_q;
    logic [MONEY_W-1:0] money_q;

    logic [QTY_W-1:0]   rd_stock;
    logic [MONEY_W-1:0] rd_price;
    logic [COST_W-1:0]  cost;
    logic               type_ok;

    logic [2:0]         err_d, err_q;
    logic [QTY_W-1:0]   new_stock_d, new_stock_q;
    logic [MONEY_W-1:0] new_price_d, new_price_q;
    logic [MONEY_W-1:0] change_d, change_q;
    logic [BANK_W-1:0]  new_bank_d, new_bank_q;
    logic [BANK_W-1:0]  bank_q;

    vending_slot_bank #(
        .N_TYPES      (N_TYPES),
        .TYPE_W       (TYPE_W),
        .QTY_W        (QTY_W),
        .MONEY_W      (MONEY_W),
        .PRICE_DEFAULT(PRICE_DEFAULT)
    ) u_slots (
        .clk     (clk),
        .reset   (reset),
        .rd_type (type_q),
        .rd_stock(rd_stock),
        .rd_price(rd_price),
        .wr_en   ((state_q == S_COMMIT) && (err_q == ERR_NONE)),
        .wr_type (type_q),
        .wr_stock(new_stock_q),
        .wr_price(new_price_q)
    );

    assign req_ready = (state_q == S_IDLE);
    assign type_ok   = (int'(type_q) < N_TYPES);
    assign cost      = COST_W'(rd_price) * COST_W'(amt_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = S_CHECK;
            S_CHECK:  state_d = S_COMMIT;
            S_COMMIT: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Error priority chain; first match wins.
    always_comb begin
        err_d       = ERR_NONE;
        new_stock_d = rd_stock;
        new_price_d = rd_price;
        new_bank_d  = bank_q;
        change_d    = (mode_q == MODE_BUY) ? money_q : '0;
        if (!type_ok)
            err_d = ERR_BADTYPE;
        else if ((mode_q == MODE_BUY || mode_q == MODE_RESTOCK) && amt_q == '0)
            err_d = ERR_ZEROQTY;
        else if (mode_q == MODE_BUY && amt_q > rd_stock)
            err_d = ERR_NOSTOCK;
        else if (mode_q == MODE_BUY && COST_W'(money_q) < cost)
            err_d = ERR_NOMONEY;
        else if (mode_q == MODE_RESTOCK &&
                 (QTY_W+1)'(rd_stock) + (QTY_W+1)'(amt_q) > (QTY_W+1)'(MAX_STOCK))
            err_d = ERR_OVERSTOCK;
        else if (mode_q == MODE_BUY && SUM_W'(bank_q) + SUM_W'(cost) > BANK_MAX)
            err_d = ERR_BANKFULL;
        else if (mode_q == MODE_SETPRICE && money_q == '0)
            err_d = ERR_ZEROPRICE;

        if (err_d == ERR_NONE) begin
            case (mode_q)
                MODE_BUY: begin
                    new_stock_d = rd_stock - amt_q;
                    new_bank_d  = bank_q + BANK_W'(cost);
                    change_d    = money_q - MONEY_W'(cost);
                end
                MODE_RESTOCK:  new_stock_d = rd_stock + amt_q;
                MODE_SETPRICE: new_price_d = money_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_QUERY;
            type_q       <= '0;
            amt_q        <= '0;
            money_q      <= '0;
            err_q        <= ERR_NONE;
            new_stock_q  <= '0;
            new_price_q  <= '0;
            change_q     <= '0;
            new_bank_q   <= '0;
            bank_q       <= '0;
            resp_valid   <= 1'b0;
            error        <= ERR_NONE;
            change       <= '0;
            stock_out    <= '0;
            machineMoney <= '0;
        end else begin
            state_q    <= state_d;
            resp_valid <= 1'b0;
            if (state_q == S_IDLE && req_valid) begin
                mode_q  <= mode;
                type_q  <= supply_type;
                amt_q   <= customer_amount;
                money_q <= customer_money;
            end
            if (state_q == S_CHECK) begin
                err_q       <= err_d;
                new_stock_q <= new_stock_d;
                new_price_q <= new_price_d;
                change_q    <= change_d;
                new_bank_q  <= new_bank_d;
            end
            if (state_q == S_COMMIT && err_q == ERR_NONE)
                bank_q <= new_bank_q;
            // Slot bank already holds the committed stock when RESP samples it.
            if (state_q == S_RESP) begin
                resp_valid   <= 1'b1;
                error        <= err_q;
                change       <= change_q;
                stock_out    <= rd_stock;
                machineMoney <= bank_q;
            end
        end
    end

endmodule

// File: tb/tb_vending_core_param.sv
// Directed bench for vending_core_param with a cycle-level reference model and scoreboard.
module tb_vending_core_param;

    localparam int NT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] mode;
    logic [3:0] supply_type;
    logic [3:0] customer_amount;
    logic [6:0] customer_money;
    logic       resp_valid;
    logic [2:0] error;
    logic [6:0] change;
    logic [3:0] stock_out;
    logic [11:0] machineMoney;

    vending_core_param #(
        .N_TYPES(NT), .TYPE_W(4), .QTY_W(4), .MAX_STOCK(15),
        .MONEY_W(7), .BANK_W(12), .PRICE_DEFAULT(5)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .mode(mode), .supply_type(supply_type), .customer_amount(customer_amount),
        .customer_money(customer_money), .resp_valid(resp_valid), .error(error),
        .change(change), .stock_out(stock_out), .machineMoney(machineMoney)
    );

    always #5 clk = ~clk;

    typedef struct {
        int err;
        int chg;
        int stk;
        int bank;
        int due;
    } exp_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int next_ok = 0;
    int hs_cyc = 0;
    int m_stock [16];
    int m_price [16];
    int m_bank;
    exp_t exp_q [$];
    exp_t held;

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference model: applies each accepted request to abstract integer state.
    always @(posedge clk) begin
        automatic exp_t e;
        automatic int t, a, m, st, cost;
        cyc++;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_stock[i] = 0;
                m_price[i] = 5;
            end
            m_bank  = 0;
            exp_q.delete();
            next_ok = cyc + 1;
            held    = '{0, 0, 0, 0, 0};
        end else if (req_valid && cyc >= next_ok) begin
            next_ok = cyc + 4;
            hs_cyc  = cyc;
            t = int'(supply_type);
            a = int'(customer_amount);
            m = int'(customer_money);
            st   = (t < NT) ? m_stock[t] : 0;
            cost = ((t < NT) ? m_price[t] : 0) * a;
            e.err = 0;
            if (t >= NT)                                        e.err = 1;
            else if ((mode == 2'd1 || mode == 2'd2) && a == 0)  e.err = 2;
            else if (mode == 2'd1 && a > st)                    e.err = 3;
            else if (mode == 2'd1 && m < cost)                  e.err = 4;
            else if (mode == 2'd2 && st + a > 15)               e.err = 5;
            else if (mode == 2'd1 && m_bank + cost > 4095)      e.err = 6;
            else if (mode == 2'd3 && m == 0)                    e.err = 7;
            e.chg = (mode == 2'd1) ? m : 0;
            if (e.err == 0) begin
                if (mode == 2'd1) begin
                    st     -= a;
                    m_bank += cost;
                    e.chg   = m - cost;
                end else if (mode == 2'd2) begin
                    st += a;
                end else if (mode == 2'd3) begin
                    m_price[t] = m;
                end
                m_stock[t] = st;
            end
            e.stk  = (t < NT) ? m_stock[t] : 0;
            e.bank = m_bank;
            e.due  = cyc + 3;
            exp_q.push_back(e);
        end
    end

    // Compare process: responses, held outputs and ready on every falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("req_ready", int'(req_ready), (cyc + 1 >= next_ok) ? 1 : 0);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", 1, 0);
                end else begin
                    held = exp_q.pop_front();
                    chk("resp_latency", cyc, held.due);
                    chk("resp_error", int'(error), held.err);
                    chk("resp_change", int'(change), held.chg);
                    chk("resp_stock", int'(stock_out), held.stk);
                    chk("resp_bank", int'(machineMoney), held.bank);
                end
            end else begin
                chk("hold_error", int'(error), held.err);
                chk("hold_change", int'(change), held.chg);
                chk("hold_stock", int'(stock_out), held.stk);
                chk("hold_bank", int'(machineMoney), held.bank);
            end
        end
    end

    task automatic do_req(input logic [1:0] md, input int t, input int amt, input int money);
        int n;
        @(negedge clk);
        mode            = md;
        supply_type     = 4'(t);
        customer_amount = 4'(amt);
        customer_money  = 7'(money);
        req_valid       = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("handshake_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) chk("resp_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        reset = 1'b1;
        req_valid = 1'b0;
        mode = 2'd0;
        supply_type = '0;
        customer_amount = '0;
        customer_money = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_valid", int'(resp_valid), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_change", int'(change), 0);
        chk("rst_stock", int'(stock_out), 0);
        chk("rst_bank", int'(machineMoney), 0);

        do_req(2'd0, 2, 0, 0);
        chk("q2_latency", cyc - hs_cyc, 3);
        chk("q2_err", int'(error), 0);
        chk("q2_stock", int'(stock_out), 0);

        do_req(2'd2, 0, 10, 0);
        chk("restock0_stock", int'(stock_out), 10);
        do_req(2'd1, 0, 2, 10);
        chk("buy0_err", int'(error), 0);
        chk("buy0_change", int'(change), 0);
        chk("buy0_stock", int'(stock_out), 8);
        chk("buy0_bank", int'(machineMoney), 10);
        do_req(2'd1, 0, 3, 10);
        chk("poor_err", int'(error), 4);
        chk("poor_change", int'(change), 10);
        chk("poor_stock", int'(stock_out), 8);
        do_req(2'd1, 0, 9, 100);
        chk("nostock_err", int'(error), 3);
        do_req(2'd1, 0, 0, 5);
        chk("zeroqty_err", int'(error), 2);
        chk("zeroqty_change", int'(change), 5);

        do_req(2'd2, 1, 15, 0);
        chk("fill1_stock", int'(stock_out), 15);
        do_req(2'd2, 1, 1, 0);
        chk("over1_err", int'(error), 5);
        chk("over1_stock", int'(stock_out), 15);
        do_req(2'd0, 9, 0, 0);
        chk("badtype_err", int'(error), 1);
        chk("badtype_stock", int'(stock_out), 0);

        do_req(2'd3, 3, 0, 20);
        chk("price3_err", int'(error), 0);
        do_req(2'd2, 3, 5, 0);
        do_req(2'd1, 3, 4, 100);
        chk("buy3_change", int'(change), 20);
        chk("buy3_bank", int'(machineMoney), 90);
        chk("buy3_stock", int'(stock_out), 1);
        do_req(2'd3, 3, 0, 0);
        chk("price0_err", int'(error), 7);

        // Fill the register to exactly 4095, then overflow by one.
        do_req(2'd3, 4, 0, 127);
        for (int i = 0; i < 31; i++) begin
            do_req(2'd2, 4, 1, 0);
            do_req(2'd1, 4, 1, 127);
        end
        chk("bank_4027", int'(machineMoney), 4027);
        do_req(2'd3, 4, 0, 68);
        do_req(2'd2, 4, 1, 0);
        do_req(2'd1, 4, 1, 68);
        chk("bankmax_err", int'(error), 0);
        chk("bankmax_bank", int'(machineMoney), 4095);
        chk("bankmax_stock", int'(stock_out), 0);
        do_req(2'd3, 4, 0, 1);
        do_req(2'd2, 4, 1, 0);
        do_req(2'd1, 4, 1, 1);
        chk("bankfull_err", int'(error), 6);
        chk("bankfull_change", int'(change), 1);
        chk("bankfull_bank", int'(machineMoney), 4095);

        // Reset while the buy is in COMMIT.
        @(negedge clk);
        mode = 2'd1; supply_type = 4'd0; customer_amount = 4'd1; customer_money = 7'd10;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("abort_no_resp", seen, 0);
        do_req(2'd0, 0, 0, 0);
        chk("abort_stock", int'(stock_out), 0);
        chk("abort_bank", int'(machineMoney), 0);

        // Extra request toggled while busy must not be accepted.
        @(negedge clk);
        mode = 2'd2; supply_type = 4'd0; customer_amount = 4'd3; customer_money = 7'd0;
        req_valid = 1'b1;
        @(negedge clk);
        customer_amount = 4'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        do_req(2'd0, 0, 0, 0);
        chk("busy_stock", int'(stock_out), 3);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
